// File: rtl/arm_pkg.sv
// Shared definitions for the arm command arbiter: default axis width,
// FSM state encoding and source codes.
package arm_pkg;

  localparam int AXIS_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DWELL = 2'd2
  } arb_state_e;

  localparam logic SRC_ROM = 1'b0;
  localparam logic SRC_MAN = 1'b1;

endpackage

// File: rtl/arm_axis_clamp.sv
// Single-axis clamp: limits an unsigned axis value to [MIN, MAX] and flags
// whether the value had to be altered.
module arm_axis_clamp #(
  parameter int W   = 10,
  parameter int MIN = 0,
  parameter int MAX = 1023
) (
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o,
  output logic         clamp_o
);

  localparam logic [W-1:0] MIN_V = W'(MIN);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  // Pass the value through unless it lies outside the legal window.
  always_comb begin
    val_o   = val_i;
    clamp_o = 1'b0;
    if (val_i < MIN_V) begin
      val_o   = MIN_V;
      clamp_o = 1'b1;
    end else if (val_i > MAX_V) begin
      val_o   = MAX_V;
      clamp_o = 1'b1;
    end
  end

endmodule

// File: rtl/arm_command_arbiter.sv
// Arbitrates between a ROM position stream and a manual position source,
// clamps the winning position, issues it as a held servo command and then
// waits a fixed dwell time before the next grant. A consecutive-grant
// counter keeps one source from starving the other.
module arm_command_arbiter #(
  parameter int AXIS_W       = arm_pkg::AXIS_W,
  parameter int AXIS_MIN     = 0,
  parameter int AXIS_MAX     = 1023,
  parameter int DWELL_CYCLES = 25_000,
  parameter int MAX_CONSEC   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_valid,
  input  logic [AXIS_W-1:0] rom_x,
  input  logic [AXIS_W-1:0] rom_y,
  input  logic [AXIS_W-1:0] rom_z,
  output logic              rom_ready,
  input  logic              man_valid,
  input  logic [AXIS_W-1:0] man_x,
  input  logic [AXIS_W-1:0] man_y,
  input  logic [AXIS_W-1:0] man_z,
  output logic              man_ready,
  input  logic              select_source,
  input  logic              stop,
  output logic              cmd_valid,
  output logic [AXIS_W-1:0] cmd_x,
  output logic [AXIS_W-1:0] cmd_y,
  output logic [AXIS_W-1:0] cmd_z,
  output logic              cmd_src,
  input  logic              cmd_ready,
  output logic              clamp_flag,
  output logic              busy
);

  import arm_pkg::*;

  localparam int DW_W = (DWELL_CYCLES > 0) ? $clog2(DWELL_CYCLES + 1) : 1;
  localparam int CW_W = (MAX_CONSEC > 0) ? $clog2(MAX_CONSEC + 1) : 1;
  // Dwell counter counts down to zero, so it is loaded with one less than
  // the dwell length to spend exactly DWELL_CYCLES cycles in DWELL.
  localparam logic [DW_W-1:0] DWELL_LOAD  = DW_W'((DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0);
  localparam logic [CW_W-1:0] CONSEC_MAX  = CW_W'(MAX_CONSEC);

  arb_state_e        state_q, state_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [CW_W-1:0]   consec_q, consec_d;
  logic              last_src_q, last_src_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [AXIS_W-1:0] cmd_x_q, cmd_x_d;
  logic [AXIS_W-1:0] cmd_y_q, cmd_y_d;
  logic [AXIS_W-1:0] cmd_z_q, cmd_z_d;
  logic              cmd_src_q, cmd_src_d;
  logic              clamp_q, clamp_d;

  logic              grant_en;
  logic              win_src;
  logic              other_valid;
  logic              xfer;
  logic [AXIS_W-1:0] sel_x, sel_y, sel_z;
  logic [AXIS_W-1:0] clp_x, clp_y, clp_z;
  logic              clamp_x, clamp_y, clamp_z;

  // Pick the winning source and drive the ready handshake combinationally.
  always_comb begin
    grant_en = rst && (state_q == ST_IDLE) && !stop;
    if (rom_valid && man_valid) begin
      win_src = select_source;
      if ((consec_q == CONSEC_MAX) && (last_src_q == select_source)) begin
        win_src = ~select_source;
      end
    end else begin
      win_src = man_valid ? SRC_MAN : SRC_ROM;
    end
    other_valid = (win_src == SRC_MAN) ? rom_valid : man_valid;
    rom_ready   = grant_en && rom_valid && (win_src == SRC_ROM);
    man_ready   = grant_en && man_valid && (win_src == SRC_MAN);
    xfer        = rom_ready || man_ready;
    sel_x       = (win_src == SRC_MAN) ? man_x : rom_x;
    sel_y       = (win_src == SRC_MAN) ? man_y : rom_y;
    sel_z       = (win_src == SRC_MAN) ? man_z : rom_z;
  end

  arm_axis_clamp #(.W(AXIS_W), .MIN(AXIS_MIN), .MAX(AXIS_MAX)) u_clamp_x (
    .val_i(sel_x), .val_o(clp_x), .clamp_o(clamp_x)
  );
  arm_axis_clamp #(.W(AXIS_W), .MIN(AXIS_MIN), .MAX(AXIS_MAX)) u_clamp_y (
    .val_i(sel_y), .val_o(clp_y), .clamp_o(clamp_y)
  );
  arm_axis_clamp #(.W(AXIS_W), .MIN(AXIS_MIN), .MAX(AXIS_MAX)) u_clamp_z (
    .val_i(sel_z), .val_o(clp_z), .clamp_o(clamp_z)
  );

  // Next-state logic for the IDLE/ISSUE/DWELL sequence and fairness counter.
  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    consec_d    = consec_q;
    last_src_d  = last_src_q;
    cmd_valid_d = cmd_valid_q;
    cmd_x_d     = cmd_x_q;
    cmd_y_d     = cmd_y_q;
    cmd_z_d     = cmd_z_q;
    cmd_src_d   = cmd_src_q;
    clamp_d     = clamp_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d     = ST_ISSUE;
          cmd_valid_d = 1'b1;
          cmd_x_d     = clp_x;
          cmd_y_d     = clp_y;
          cmd_z_d     = clp_z;
          cmd_src_d   = win_src;
          clamp_d     = clamp_x || clamp_y || clamp_z;
          last_src_d  = win_src;
          // Only grants made against a waiting competitor count toward the
          // streak; a switch of source restarts it.
          if (win_src == last_src_q) begin
            if (other_valid && (consec_q != CONSEC_MAX)) begin
              consec_d = consec_q + CW_W'(1);
            end
          end else begin
            consec_d = other_valid ? CW_W'(1) : '0;
          end
        end
      end
      ST_ISSUE: begin
        if (stop) begin
          state_d     = ST_IDLE;
          cmd_valid_d = 1'b0;
        end else if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          dwell_d     = DWELL_LOAD;
          state_d     = (DWELL_CYCLES == 0) ? ST_IDLE : ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (stop || (dwell_q == '0)) begin
          state_d = ST_IDLE;
        end else begin
          dwell_d = dwell_q - DW_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase
  end

  // State and command registers; reset clears everything including data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      dwell_q     <= '0;
      consec_q    <= '0;
      last_src_q  <= SRC_ROM;
      cmd_valid_q <= 1'b0;
      cmd_x_q     <= '0;
      cmd_y_q     <= '0;
      cmd_z_q     <= '0;
      cmd_src_q   <= SRC_ROM;
      clamp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      consec_q    <= consec_d;
      last_src_q  <= last_src_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_x_q     <= cmd_x_d;
      cmd_y_q     <= cmd_y_d;
      cmd_z_q     <= cmd_z_d;
      cmd_src_q   <= cmd_src_d;
      clamp_q     <= clamp_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_x      = cmd_x_q;
  assign cmd_y      = cmd_y_q;
  assign cmd_z      = cmd_z_q;
  assign cmd_src    = cmd_src_q;
  assign clamp_flag = clamp_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
